// File: rtl/cntr8_seq_ctrl_if.sv
// Interface bundling the two requester channels and the cntr8 control outputs
// of the cntr8_seq_ctrl command sequencer. The master modport is the
// host/requester side. The slave modport is the sequencer itself.
interface cntr8_seq_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              req0;
    logic              req1;
    logic [1:0]        op0;
    logic [1:0]        op1;
    logic [WIDTH-1:0]  data0;
    logic [WIDTH-1:0]  data1;
    logic [STEP_W-1:0] steps0;
    logic [STEP_W-1:0] steps1;
    logic              ack0;
    logic              ack1;
    logic              done0;
    logic              done1;
    logic              busy;
    logic              cnt_load;
    logic              cnt_inc;
    logic              cnt_en;
    logic [WIDTH-1:0]  cnt_d;

    modport master (
        output req0, req1, op0, op1, data0, data1, steps0, steps1,
        input  ack0, ack1, done0, done1, busy, cnt_load, cnt_inc, cnt_en, cnt_d
    );

    modport slave (
        input  req0, req1, op0, op1, data0, data1, steps0, steps1,
        output ack0, ack1, done0, done1, busy, cnt_load, cnt_inc, cnt_en, cnt_d
    );
endinterface

// File: rtl/cntr8_seq_ctrl.sv
// cntr8_seq_ctrl: arbitrates LOAD/UP/DOWN/NOP commands from two requesters
// and drives the load/inc/enable controls of the cntr8 counter datapath.
// Define CNTR_SEQ_PRIO_EN for fixed priority (requester 0 always wins).
// Leave it undefined for round-robin arbitration, which is the default.
module cntr8_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    cntr8_seq_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    state_t            state;
    logic              grant;
    logic              pick1;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] remaining;

    logic              ack0_q;
    logic              ack1_q;
    logic              done0_q;
    logic              done1_q;
    logic              busy_q;
    logic              cnt_load_q;
    logic              cnt_inc_q;
    logic              cnt_en_q;
    logic [WIDTH-1:0]  cnt_d_q;

`ifdef CNTR_SEQ_PRIO_EN
    // Fixed priority: requester 1 is only chosen when requester 0 is quiet.
    always_comb begin
        pick1 = bus.req1 && !bus.req0;
    end
`else
    logic last_grant;

    // Round-robin: on contention, choose the requester that did not finish last.
    always_comb begin
        pick1 = bus.req1 && (!bus.req0 || !last_grant);
    end

    // Remember which requester completed most recently; reset favours requester 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (state == DONE) begin
            last_grant <= grant;
        end
    end
`endif

    // Sequencer FSM: grant and latch in IDLE, drive the counter in EXEC, pulse done in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            cmd_op     <= 2'b00;
            cmd_data   <= '0;
            remaining  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
            cnt_load_q <= 1'b0;
            cnt_inc_q  <= 1'b0;
            cnt_en_q   <= 1'b0;
            cnt_d_q    <= '0;
        end else begin
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            cnt_load_q <= 1'b0;
            cnt_inc_q  <= 1'b0;
            cnt_en_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        grant     <= pick1;
                        ack0_q    <= !pick1;
                        ack1_q    <= pick1;
                        busy_q    <= 1'b1;
                        cmd_op    <= pick1 ? bus.op1    : bus.op0;
                        cmd_data  <= pick1 ? bus.data1  : bus.data0;
                        remaining <= pick1 ? bus.steps1 : bus.steps0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    case (cmd_op)
                        OP_LOAD: begin
                            cnt_load_q <= 1'b1;
                            cnt_d_q    <= cmd_data;
                            state      <= DONE;
                        end
                        OP_UP, OP_DOWN: begin
                            if (remaining != '0) begin
                                cnt_en_q  <= 1'b1;
                                cnt_inc_q <= (cmd_op == OP_UP);
                                remaining <= remaining - STEP_W'(1);
                                if (remaining == STEP_W'(1)) begin
                                    state <= DONE;
                                end
                            end else begin
                                state <= DONE;
                            end
                        end
                        default: begin
                            state <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    done0_q <= !grant;
                    done1_q <= grant;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.busy     = busy_q;
    assign bus.cnt_load = cnt_load_q;
    assign bus.cnt_inc  = cnt_inc_q;
    assign bus.cnt_en   = cnt_en_q;
    assign bus.cnt_d    = cnt_d_q;

endmodule

// File: tb/tb_cntr8_seq_ctrl.sv
// Directed testbench for cntr8_seq_ctrl. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge. Expected values for the
// second arbitration depend on CNTR_SEQ_PRIO_EN.
module tb_cntr8_seq_ctrl;

    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DOWN = 2'b10;
    localparam logic [1:0] NOP  = 2'b11;

`ifdef CNTR_SEQ_PRIO_EN
    localparam int SECOND_GRANT = 0;
`else
    localparam int SECOND_GRANT = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   assert_count = 0;
    int   fail_count   = 0;

    cntr8_seq_ctrl_if #(.WIDTH(8), .STEP_W(4)) bus ();

    cntr8_seq_ctrl #(.WIDTH(8), .STEP_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int who, input logic [1:0] op,
                                 input logic [7:0] data, input logic [3:0] steps);
        if (who == 0) begin
            bus.req0 = 1'b1; bus.op0 = op; bus.data0 = data; bus.steps0 = steps;
        end else begin
            bus.req1 = 1'b1; bus.op1 = op; bus.data1 = data; bus.steps1 = steps;
        end
    endtask

    task automatic dropRequest(input int who);
        if (who == 0) bus.req0 = 1'b0;
        else          bus.req1 = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack0"},     bus.ack0,     0);
        checkOutput({tag, "_ack1"},     bus.ack1,     0);
        checkOutput({tag, "_done0"},    bus.done0,    0);
        checkOutput({tag, "_done1"},    bus.done1,    0);
        checkOutput({tag, "_busy"},     bus.busy,     0);
        checkOutput({tag, "_cnt_load"}, bus.cnt_load, 0);
        checkOutput({tag, "_cnt_inc"},  bus.cnt_inc,  0);
        checkOutput({tag, "_cnt_en"},   bus.cnt_en,   0);
        checkOutput({tag, "_cnt_d"},    bus.cnt_d,    0);
    endtask

    // Load and step enable must never be driven to the counter together.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            checkOutput("no_load_en_overlap", bus.cnt_load & bus.cnt_en, 0);
        end
    end

    // Directed test sequence.
    initial begin
        reset_n = 1'b0;
        bus.req0 = 1'b0; bus.op0 = NOP; bus.data0 = 8'h00; bus.steps0 = 4'd0;
        bus.req1 = 1'b0; bus.op1 = NOP; bus.data1 = 8'h00; bus.steps1 = 4'd0;
        repeat (3) step();
        checkAllZero("reset");
        reset_n = 1'b1;
        step();

        // Test 1: requester 0 LOAD 0xA5.
        applyStimulus(0, LOAD, 8'hA5, 4'd0);
        step();
        checkOutput("t1_ack0", bus.ack0, 1);
        checkOutput("t1_busy_ack", bus.busy, 1);
        checkOutput("t1_no_load_yet", bus.cnt_load, 0);
        dropRequest(0);
        step();
        checkOutput("t1_ack0_pulse", bus.ack0, 0);
        checkOutput("t1_cnt_load", bus.cnt_load, 1);
        checkOutput("t1_cnt_d", bus.cnt_d, 8'hA5);
        checkOutput("t1_cnt_en", bus.cnt_en, 0);
        step();
        checkOutput("t1_done0", bus.done0, 1);
        checkOutput("t1_done1", bus.done1, 0);
        checkOutput("t1_load_off", bus.cnt_load, 0);
        checkOutput("t1_busy_off", bus.busy, 0);
        step();
        checkOutput("t1_done0_pulse", bus.done0, 0);
        checkOutput("t1_cnt_d_hold", bus.cnt_d, 8'hA5);

        // Test 2: requester 1 UP for 5 cycles.
        applyStimulus(1, UP, 8'h00, 4'd5);
        step();
        checkOutput("t2_ack1", bus.ack1, 1);
        checkOutput("t2_ack0", bus.ack0, 0);
        dropRequest(1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("t2_cnt_en", bus.cnt_en, 1);
            checkOutput("t2_cnt_inc", bus.cnt_inc, 1);
            checkOutput("t2_done1_early", bus.done1, 0);
        end
        step();
        checkOutput("t2_en_stop", bus.cnt_en, 0);
        checkOutput("t2_done1", bus.done1, 1);
        step();
        checkOutput("t2_done1_pulse", bus.done1, 0);

        // Test 3: two contentions in a row.
        applyStimulus(0, LOAD, 8'h11, 4'd0);
        applyStimulus(1, LOAD, 8'h22, 4'd0);
        step();
        checkOutput("t3_first_ack0", bus.ack0, 1);
        checkOutput("t3_first_ack1", bus.ack1, 0);
        dropRequest(0);
        step();
        checkOutput("t3_first_cnt_d", bus.cnt_d, 8'h11);
        step();
        checkOutput("t3_first_done0", bus.done0, 1);
        applyStimulus(0, LOAD, 8'h33, 4'd0);
        step();
        checkOutput("t3_second_ack0", bus.ack0, SECOND_GRANT == 0);
        checkOutput("t3_second_ack1", bus.ack1, SECOND_GRANT == 1);
        dropRequest(SECOND_GRANT);
        step();
        checkOutput("t3_second_cnt_d", bus.cnt_d, (SECOND_GRANT == 1) ? 8'h22 : 8'h33);
        step();
        checkOutput("t3_second_done0", bus.done0, SECOND_GRANT == 0);
        checkOutput("t3_second_done1", bus.done1, SECOND_GRANT == 1);
`ifdef CNTR_SEQ_PRIO_EN
        step();
        checkOutput("t3_drain_ack1", bus.ack1, 1);
        dropRequest(1);
        step();
        checkOutput("t3_drain_cnt_d", bus.cnt_d, 8'h22);
        step();
        checkOutput("t3_drain_done1", bus.done1, 1);
`else
        dropRequest(0);
`endif
        step();

        // Test 4: DOWN with zero steps, then NOP.
        applyStimulus(0, DOWN, 8'hFF, 4'd0);
        step();
        checkOutput("t4a_ack0", bus.ack0, 1);
        checkOutput("t4a_busy_ack", bus.busy, 1);
        dropRequest(0);
        step();
        checkOutput("t4a_busy_exec", bus.busy, 1);
        checkOutput("t4a_cnt_en", bus.cnt_en, 0);
        checkOutput("t4a_cnt_load", bus.cnt_load, 0);
        step();
        checkOutput("t4a_done0", bus.done0, 1);
        checkOutput("t4a_busy_done", bus.busy, 0);
        checkOutput("t4a_cnt_d_hold", bus.cnt_d, 8'h22);
        applyStimulus(0, NOP, 8'h77, 4'd9);
        step();
        checkOutput("t4b_ack0", bus.ack0, 1);
        dropRequest(0);
        step();
        checkOutput("t4b_cnt_en", bus.cnt_en, 0);
        checkOutput("t4b_cnt_load", bus.cnt_load, 0);
        step();
        checkOutput("t4b_done0", bus.done0, 1);
        checkOutput("t4b_cnt_d_hold", bus.cnt_d, 8'h22);
        step();
        checkOutput("t4b_busy_idle", bus.busy, 0);

        // Test 5: asynchronous reset in the middle of DOWN 15.
        applyStimulus(0, DOWN, 8'h00, 4'd15);
        step();
        checkOutput("t5_ack0", bus.ack0, 1);
        dropRequest(0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t5_cnt_en", bus.cnt_en, 1);
            checkOutput("t5_cnt_inc", bus.cnt_inc, 0);
        end
        #2 reset_n = 1'b0;
        #1 checkAllZero("t5_async");
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t5_no_done0", bus.done0, 0);
        end
        reset_n = 1'b1;
        step();
        checkOutput("t5_idle_after_release", bus.busy, 0);
        applyStimulus(1, LOAD, 8'h3C, 4'd0);
        step();
        checkOutput("t5_ack1", bus.ack1, 1);
        dropRequest(1);
        step();
        checkOutput("t5_cnt_load", bus.cnt_load, 1);
        checkOutput("t5_cnt_d", bus.cnt_d, 8'h3C);
        step();
        checkOutput("t5_done1", bus.done1, 1);
        checkOutput("t5_done0", bus.done0, 0);
        step();

        // Test 6: requester 1 arrives while requester 0 runs DOWN 3.
        applyStimulus(0, DOWN, 8'h00, 4'd3);
        step();
        checkOutput("t6_ack0", bus.ack0, 1);
        dropRequest(0);
        applyStimulus(1, LOAD, 8'h55, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t6_cnt_en", bus.cnt_en, 1);
            checkOutput("t6_cnt_inc", bus.cnt_inc, 0);
            checkOutput("t6_ack1_wait", bus.ack1, 0);
        end
        step();
        checkOutput("t6_done0", bus.done0, 1);
        checkOutput("t6_ack1_not_yet", bus.ack1, 0);
        checkOutput("t6_en_stop", bus.cnt_en, 0);
        step();
        checkOutput("t6_ack1", bus.ack1, 1);
        dropRequest(1);
        step();
        checkOutput("t6_cnt_load", bus.cnt_load, 1);
        checkOutput("t6_cnt_d", bus.cnt_d, 8'h55);
        step();
        checkOutput("t6_done1", bus.done1, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
